// File: rtl/rx_burst_ctrl_if.sv
// Receive-burst control bundle: enable/detect/lock inputs toward the controller,
// datapath gate, burst pulses and state code back out.
interface rx_burst_ctrl_if;
  logic       enable;
  logic       SD_flag;
  logic       sync_lock;
  logic       rx_en;
  logic       burst_start;
  logic       burst_end;
  logic       burst_abort;
  logic [2:0] state;

  modport master (
    output enable, SD_flag, sync_lock,
    input  rx_en, burst_start, burst_end, burst_abort, state
  );

  modport slave (
    input  enable, SD_flag, sync_lock,
    output rx_en, burst_start, burst_end, burst_abort, state
  );
endinterface

// File: rtl/rx_burst_ctrl.sv
// Burst receive controller: debounce signal detect, wait for frame lock, bound burst length, hold off.
// Define RX_BURST_STATS_EN to add saturating burst/abort/end statistics counters.
module rx_burst_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rx_burst_ctrl_if.slave       rx_if,
  input  logic [CNT_WIDTH-1:0] RX_ARM_CYCLES,
  input  logic [CNT_WIDTH-1:0] RX_LOCK_TIMEOUT,
  input  logic [CNT_WIDTH-1:0] RX_MAX_LEN,
  input  logic [CNT_WIDTH-1:0] RX_HOLDOFF
`ifdef RX_BURST_STATS_EN
  ,
  output logic [15:0]          stat_bursts,
  output logic [15:0]          stat_aborts,
  output logic [15:0]          stat_ends
`endif
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  localparam cnt_t ONE = cnt_t'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_ACQ  = 3'd2,
    S_RX   = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t state_q;
  logic   rx_en_q, start_q, end_q, abort_q;
  cnt_t   arm_cnt_q, lock_cnt_q, len_cnt_q, hold_cnt_q;
  cnt_t   arm_lim_q, lock_lim_q, len_lim_q, hold_lim_q;

  function automatic cnt_t sat_inc(cnt_t v);
    return (v == '1) ? v : v + ONE;
  endfunction

  // Cycle budgets are stored as "last allowed index"; a zero budget still spends one cycle.
  function automatic cnt_t last_idx(cnt_t v);
    return (v == '0) ? '0 : v - ONE;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rx_en_q    <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      abort_q    <= 1'b0;
      arm_cnt_q  <= '0;
      lock_cnt_q <= '0;
      len_cnt_q  <= '0;
      hold_cnt_q <= '0;
      arm_lim_q  <= '0;
      lock_lim_q <= '0;
      len_lim_q  <= '0;
      hold_lim_q <= '0;
    end else begin
      start_q <= 1'b0;
      end_q   <= 1'b0;
      abort_q <= 1'b0;
      if (!rx_if.enable) begin
        if (state_q == S_ACQ || state_q == S_RX) abort_q <= 1'b1;
        state_q <= S_IDLE;
        rx_en_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rx_if.SD_flag) begin
              arm_lim_q  <= (RX_ARM_CYCLES == '0) ? ONE : RX_ARM_CYCLES;
              lock_lim_q <= last_idx(RX_LOCK_TIMEOUT);
              len_lim_q  <= last_idx(RX_MAX_LEN);
              hold_lim_q <= last_idx(RX_HOLDOFF);
              arm_cnt_q  <= ONE;
              state_q    <= S_ARM;
            end
          end
          S_ARM: begin
            if (!rx_if.SD_flag) begin
              state_q <= S_IDLE;
            end else if (arm_cnt_q >= arm_lim_q) begin
              state_q    <= S_ACQ;
              rx_en_q    <= 1'b1;
              start_q    <= 1'b1;
              lock_cnt_q <= '0;
            end else begin
              arm_cnt_q <= sat_inc(arm_cnt_q);
            end
          end
          S_ACQ: begin
            // Detect loss and timeout both outrank a simultaneous lock.
            if (!rx_if.SD_flag || lock_cnt_q >= lock_lim_q) begin
              state_q    <= S_HOLD;
              rx_en_q    <= 1'b0;
              abort_q    <= 1'b1;
              hold_cnt_q <= '0;
            end else if (rx_if.sync_lock) begin
              state_q   <= S_RX;
              len_cnt_q <= '0;
            end else begin
              lock_cnt_q <= sat_inc(lock_cnt_q);
            end
          end
          S_RX: begin
            if (!rx_if.SD_flag || len_cnt_q >= len_lim_q) begin
              state_q    <= S_HOLD;
              rx_en_q    <= 1'b0;
              end_q      <= !rx_if.SD_flag;
              abort_q    <= rx_if.SD_flag;
              hold_cnt_q <= '0;
            end else begin
              len_cnt_q <= sat_inc(len_cnt_q);
            end
          end
          S_HOLD: begin
            if (hold_cnt_q >= hold_lim_q) begin
              state_q <= S_IDLE;
            end else begin
              hold_cnt_q <= sat_inc(hold_cnt_q);
            end
          end
          default: begin
            state_q <= S_IDLE;
            rx_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_if.state       = state_q;
  assign rx_if.rx_en       = rx_en_q;
  assign rx_if.burst_start = start_q;
  assign rx_if.burst_end   = end_q;
  assign rx_if.burst_abort = abort_q;

`ifdef RX_BURST_STATS_EN
  logic [15:0] stat_bursts_q, stat_bursts_d;
  logic [15:0] stat_aborts_q, stat_aborts_d;
  logic [15:0] stat_ends_q,   stat_ends_d;

  always_comb begin
    stat_bursts_d = stat_bursts_q;
    stat_aborts_d = stat_aborts_q;
    stat_ends_d   = stat_ends_q;
    if (start_q && stat_bursts_q != 16'hFFFF) stat_bursts_d = stat_bursts_q + 16'd1;
    if (abort_q && stat_aborts_q != 16'hFFFF) stat_aborts_d = stat_aborts_q + 16'd1;
    if (end_q   && stat_ends_q   != 16'hFFFF) stat_ends_d   = stat_ends_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_bursts_q <= '0;
      stat_aborts_q <= '0;
      stat_ends_q   <= '0;
    end else begin
      stat_bursts_q <= stat_bursts_d;
      stat_aborts_q <= stat_aborts_d;
      stat_ends_q   <= stat_ends_d;
    end
  end

  assign stat_bursts = stat_bursts_q;
  assign stat_aborts = stat_aborts_q;
  assign stat_ends   = stat_ends_q;
`endif

endmodule
